// File: rtl/rt_mem_preloader.sv
// Firmware preloader: streams words into the data memory over port B, one acknowledged
// write per word, then hands port B back to the core and raises fetch enable.
module rt_mem_preloader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 22,
  parameter int ADDR_STEP      = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int FUNCT_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    num_words_i,
  input  logic                    src_valid_i,
  input  logic [DATA_WIDTH-1:0]   src_data_i,
  output logic                    src_ready_o,
  input  logic                    core_en_i,
  input  logic                    core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] core_be_i,
  input  logic [FUNCT_WIDTH-1:0]  core_funct_i,
  input  logic                    core_we_funct_i,
  output logic                    core_rvalid_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [FUNCT_WIDTH-1:0]  mem_funct_o,
  output logic                    mem_we_funct_o,
  input  logic                    mem_rvalid_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [CNT_WIDTH-1:0]    words_written_o,
  output logic                    fetch_enable_o
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {IDLE, FETCH, REQ, WAIT, GAP, DRAIN, DONE, ERROR} state_t;

  // With no drain configured the loader skips straight to DONE.
  localparam state_t AFTER_LOAD = (DRAIN_CYCLES == 0) ? DONE : DRAIN;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CNT_WIDTH-1:0]    num;
  logic [CNT_WIDTH-1:0]    count;
  logic [TMR_W-1:0]        timer;
  logic [DRN_W-1:0]        drain;
  logic [DATA_WIDTH-1:0]   word;
  logic                    accept;
  logic                    last;
  logic                    timeout;
  logic                    drain_end;

  assign accept          = src_ready_o & src_valid_i;
  assign last            = (count + CNT_ONE) == num;
  assign timeout         = timer == TMR_W'(TIMEOUT_CYCLES - 1);
  assign drain_end       = drain == DRN_W'(DRAIN_CYCLES - 1);
  assign words_written_o = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (num_words_i == '0) ? AFTER_LOAD : FETCH;
      FETCH:   if (accept) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      // rvalid is tested first so it wins over a simultaneous timeout
      WAIT:    if (mem_rvalid_i) state_nxt = GAP;
               else if (timeout) state_nxt = ERROR;
      GAP:     state_nxt = last ? AFTER_LOAD : FETCH;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o         = 1'b0;
    src_ready_o    = 1'b0;
    done_o         = 1'b0;
    error_o        = 1'b0;
    fetch_enable_o = 1'b0;
    case (state)
      FETCH:              begin busy_o = 1'b1; src_ready_o = 1'b1; end
      REQ, WAIT, GAP, DRAIN: busy_o = 1'b1;
      DONE:               begin done_o = 1'b1; fetch_enable_o = 1'b1; end
      ERROR:              error_o = 1'b1;
      default:            ;
    endcase
    // Port B belongs to the loader while busy; core requests are dropped, not queued.
    if (busy_o) begin
      mem_en_o       = (state == REQ);
      mem_we_o       = 1'b1;
      mem_addr_o     = addr;
      mem_wdata_o    = word;
      mem_be_o       = '1;
      mem_funct_o    = '0;
      mem_we_funct_o = 1'b0;
      core_rvalid_o  = 1'b0;
    end else begin
      mem_en_o       = core_en_i;
      mem_we_o       = core_we_i;
      mem_addr_o     = core_addr_i;
      mem_wdata_o    = core_wdata_i;
      mem_be_o       = core_be_i;
      mem_funct_o    = core_funct_i;
      mem_we_funct_o = core_we_funct_i;
      core_rvalid_o  = mem_rvalid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr  <= '0;
      num   <= '0;
      count <= '0;
      timer <= '0;
      drain <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          addr  <= base_addr_i;
          num   <= num_words_i;
          count <= '0;
          drain <= '0;
        end
        REQ:   timer <= '0;
        WAIT:  timer <= timer + TMR_W'(1);
        GAP: begin
          count <= count + CNT_ONE;
          addr  <= addr + ADDR_WIDTH'(ADDR_STEP);
          drain <= '0;
        end
        DRAIN: drain <= drain + DRN_W'(1);
        default: ;
      endcase
    end
  end

  // Stream word holding register; pure data, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) word <= src_data_i;
  end

endmodule
